// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared constants, state encoding and lane helpers for the
//               MEM-stage load/store front end.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // RV32I load/store width and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Read-modify-write sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Byte-lane enables within a little-endian 32-bit word
    localparam logic [3:0] MASK_B0   = 4'b0001;
    localparam logic [3:0] MASK_H_LO = 4'b0011;
    localparam logic [3:0] MASK_H_HI = 4'b1100;
    localparam logic [3:0] MASK_W    = 4'b1111;

    // Replace the enabled byte lanes of old_word with those of new_word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational byte/half lane select with sign or zero
//               extension. Also reports which byte lanes the access touches,
//               so the store merge path shares the same lane decode.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data,
    output logic [3:0]  lane_mask
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane mux: pick the addressed byte/half and the matching lane enables
    always_comb begin
        sel_byte  = rdata[7:0];
        sel_half  = rdata[15:0];
        lane_mask = MASK_W;
        case (lane)
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            2'd3:    sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        if (lane[1]) begin
            sel_half = rdata[31:16];
        end
        case (funct3)
            F3_B, F3_BU: lane_mask = MASK_B0 << lane;
            F3_H, F3_HU: lane_mask = lane[1] ? MASK_H_HI : MASK_H_LO;
            default:     lane_mask = MASK_W;
        endcase
    end

    // Extension of the selected lane according to width/sign code
    always_comb begin
        ext_data = '0;
        case (funct3)
            F3_B:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    ext_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    ext_data = rdata;
            F3_BU:   ext_data = {24'd0, sel_byte};
            F3_HU:   ext_data = {16'd0, sel_half};
            default: ext_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store front end. Single-cycle loads with lane
//               extraction; SW written directly; SB/SH performed as a
//               two-cycle read-modify-write because the memory only supports
//               whole-word writes. Alignment/illegal-code faults are flagged
//               combinationally and recorded in sticky fault registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_enable,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_stall,
    output logic              o_fault,
    output logic              o_fault_sticky,
    output logic [ADDR_W-1:0] o_fault_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_write,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_merge;

    logic [ADDR_W-1:0] aligned_addr;
    logic              code_ok;
    logic              misaligned;
    logic              req_idle;
    logic              req_ok;
    logic              do_load;
    logic              do_sw;
    logic              do_rmw;
    logic [DATA_W-1:0] ext_data;
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] store_rep;

    assign aligned_addr = {i_addr[ADDR_W-1:2], 2'b00};

    // Decode legality and alignment of the requested width/sign code
    always_comb begin
        code_ok    = 1'b0;
        misaligned = 1'b0;
        case (i_funct3)
            F3_B:    code_ok = 1'b1;
            F3_H:    begin code_ok = 1'b1;          misaligned = i_addr[0];    end
            F3_W:    begin code_ok = 1'b1;          misaligned = |i_addr[1:0]; end
            F3_BU:   code_ok = ~i_req_write;
            F3_HU:   begin code_ok = ~i_req_write;  misaligned = i_addr[0];    end
            default: code_ok = 1'b0;
        endcase
    end

    // Requests are only decoded in IDLE; WRITE works from latched values
    assign req_idle = (state == ST_IDLE) && i_req_valid;
    assign o_fault  = req_idle && (~code_ok || misaligned);
    assign req_ok   = req_idle && ~o_fault;
    assign do_load  = req_ok && ~i_req_write;
    assign do_sw    = req_ok && i_req_write && (i_funct3 == F3_W);
    assign do_rmw   = req_ok && i_req_write && (i_funct3 != F3_W);

    load_extract u_load_extract (
        .rdata     (i_mem_rdata),
        .lane      (i_addr[1:0]),
        .funct3    (i_funct3),
        .ext_data  (ext_data),
        .lane_mask (lane_mask)
    );

    assign o_rdata   = do_load ? ext_data : '0;
    assign store_rep = (i_funct3 == F3_B) ? {4{i_wdata[7:0]}} : {2{i_wdata[15:0]}};

    // State register; an asynchronous reset abandons a pending write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else if (i_clk_enable) begin
            state <= state_next;
        end
    end

    // Next state and memory-side outputs
    always_comb begin
        state_next  = state;
        o_mem_addr  = aligned_addr;
        o_mem_wdata = i_wdata;
        o_mem_write = 1'b0;
        o_stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (do_sw) begin
                    o_mem_addr  = i_addr;
                    o_mem_write = 1'b1;
                end else if (do_rmw) begin
                    o_stall    = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                o_mem_addr  = r_addr;
                o_mem_wdata = r_merge;
                o_mem_write = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Reset must silence the memory port immediately, not at the next edge
        if (i_rst) begin
            o_mem_write = 1'b0;
            o_stall     = 1'b0;
        end
    end

    // Capture the merged word and its address during the read phase of SB/SH
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_merge <= '0;
        end else if (i_clk_enable && do_rmw) begin
            r_addr  <= aligned_addr;
            r_merge <= merge_lanes(i_mem_rdata, store_rep, lane_mask);
        end
    end

    // Record faults: sticky flag plus the most recent faulting address
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fault_sticky <= 1'b0;
            o_fault_addr   <= '0;
        end else if (i_clk_enable && o_fault) begin
            o_fault_sticky <= 1'b1;
            o_fault_addr   <= i_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               word-write memory model and an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_enable;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        fault_sticky;
    logic [31:0] fault_addr;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:15];
    logic        init_done = 1'b0;
    int          wr_count  = 0;
    int          wr0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clk_enable   (clk_enable),
        .i_req_valid    (req_valid),
        .i_req_write    (req_write),
        .i_funct3       (funct3),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_rdata        (rdata),
        .o_stall        (stall),
        .o_fault        (fault),
        .o_fault_sticky (fault_sticky),
        .o_fault_addr   (fault_addr),
        .o_mem_addr     (mem_addr),
        .o_mem_write    (mem_write),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    // Combinational-read memory
    assign mem_rdata = mem[mem_addr[5:2]];

    // Preload on the first edge, then word writes on enabled edges
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0]    <= 32'h03020100;
            mem[1]    <= 32'h07060504;
            mem[2]    <= 32'h0b0a0908;
            mem[5]    <= 32'hcdab0000;
            mem[6]    <= 32'h0000efef;
            init_done <= 1'b1;
        end else if (mem_write && clk_enable) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            wr_count           <= wr_count + 1;
        end
    end

    task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        funct3    = f3;
        addr      = a;
        wdata     = d;
    endtask

    task automatic push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clk_enable = 1'b1;
        drive(0, 0, F3_B, 32'h0, 32'h0);

        // Reset state
        @(negedge clk);
        drive(1, 1, F3_B, 32'h5, 32'h11);
        push(0); push(0); push(0); push(0);
        #1;
        check("rst_stall", {31'd0, stall});
        check("rst_mem_write", {31'd0, mem_write});
        check("rst_sticky", {31'd0, fault_sticky});
        check("rst_fault_addr", fault_addr);
        @(negedge clk);
        drive(0, 0, F3_B, 32'h0, 32'h0);
        rst = 1'b0;

        // Loads
        @(negedge clk);
        drive(1, 0, F3_W, 32'h4, 32'h0);
        push(32'h07060504); push(0); push(0);
        #1;
        check("lw4_rdata", rdata);
        check("lw4_stall", {31'd0, stall});
        check("lw4_mem_write", {31'd0, mem_write});
        @(negedge clk);
        drive(1, 0, F3_B, 32'h18, 32'h0);
        push(32'hffffffef);
        #1 check("lb18", rdata);
        @(negedge clk);
        drive(1, 0, F3_BU, 32'h18, 32'h0);
        push(32'h000000ef);
        #1 check("lbu18", rdata);
        @(negedge clk);
        drive(1, 0, F3_HU, 32'h2, 32'h0);
        push(32'h00000302);
        #1 check("lhu2", rdata);
        @(negedge clk);
        drive(1, 0, F3_H, 32'h16, 32'h0);
        push(32'hffffcdab);
        #1 check("lh16", rdata);

        // SB read-modify-write
        @(negedge clk);
        drive(1, 1, F3_B, 32'h5, 32'h123456AA);
        push(1); push(32'h4); push(0); push(0);
        #1;
        check("sb_c1_stall", {31'd0, stall});
        check("sb_c1_mem_addr", mem_addr);
        check("sb_c1_mem_write", {31'd0, mem_write});
        check("sb_c1_fault", {31'd0, fault});
        @(negedge clk);
        drive(1, 1, F3_W, 32'h20, 32'hffffffff);
        push(1); push(32'h4); push(32'h0706AA04); push(0);
        #1;
        check("sb_c2_mem_write", {31'd0, mem_write});
        check("sb_c2_mem_addr", mem_addr);
        check("sb_c2_mem_wdata", mem_wdata);
        check("sb_c2_stall", {31'd0, stall});
        @(negedge clk);
        drive(1, 0, F3_W, 32'h4, 32'h0);
        push(32'h0706AA04);
        #1 check("sb_readback", rdata);

        // Faults
        @(negedge clk);
        drive(1, 1, F3_H, 32'h3, 32'hBEEF);
        push(1); push(0); push(0); push(0);
        #1;
        check("sh3_fault", {31'd0, fault});
        check("sh3_mem_write", {31'd0, mem_write});
        check("sh3_stall", {31'd0, stall});
        check("sh3_rdata", rdata);
        @(negedge clk);
        drive(0, 0, F3_B, 32'h0, 32'h0);
        push(1); push(32'h3); push(0);
        #1;
        check("sh3_sticky", {31'd0, fault_sticky});
        check("sh3_fault_addr", fault_addr);
        check("idle_fault", {31'd0, fault});
        @(negedge clk);
        drive(1, 0, 3'b011, 32'h10, 32'h0);
        push(1); push(0);
        #1;
        check("f3_011_fault", {31'd0, fault});
        check("f3_011_rdata", rdata);
        @(negedge clk);
        drive(1, 1, F3_BU, 32'h8, 32'h0);
        push(1); push(32'h10); push(0);
        #1;
        check("sbu_fault", {31'd0, fault});
        check("f3_011_fault_addr", fault_addr);
        check("sbu_mem_write", {31'd0, mem_write});
        @(negedge clk);
        drive(1, 0, F3_W, 32'h2, 32'h0);
        push(1); push(0);
        #1;
        check("lw2_fault", {31'd0, fault});
        check("lw2_rdata", rdata);
        @(negedge clk);
        drive(1, 0, F3_HU, 32'h1, 32'h0);
        push(1); push(32'h2);
        #1;
        check("lhu1_fault", {31'd0, fault});
        check("lw2_fault_addr", fault_addr);

        // SH with clock enable held low while in WRITE
        @(negedge clk);
        drive(1, 1, F3_H, 32'h2, 32'h0000BEEF);
        push(1);
        #1 check("sh2_c1_stall", {31'd0, stall});
        @(negedge clk);
        clk_enable = 1'b0;
        drive(1, 1, F3_W, 32'h8, 32'h12345678);
        wr0 = wr_count;
        push(1); push(32'h0); push(32'hBEEF0100); push(0);
        #1;
        check("sh2_hold_write", {31'd0, mem_write});
        check("sh2_hold_addr", mem_addr);
        check("sh2_hold_wdata", mem_wdata);
        check("sh2_hold_fault", {31'd0, fault});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push(1); push(32'hBEEF0100);
            #1;
            check("sh2_held_write", {31'd0, mem_write});
            check("sh2_held_wdata", mem_wdata);
        end
        @(negedge clk);
        clk_enable = 1'b1;
        drive(0, 0, F3_B, 32'h0, 32'h0);
        @(negedge clk);
        push(0); push(1);
        #1;
        check("sh2_after_write", {31'd0, mem_write});
        check("sh2_write_count", wr_count - wr0);
        @(negedge clk);
        drive(1, 0, F3_W, 32'h0, 32'h0);
        push(32'hBEEF0100);
        #1 check("sh2_readback", rdata);

        // SW direct write
        @(negedge clk);
        drive(1, 1, F3_W, 32'h8, 32'hdeadbeef);
        push(1); push(32'h8); push(32'hdeadbeef); push(0);
        #1;
        check("sw8_mem_write", {31'd0, mem_write});
        check("sw8_mem_addr", mem_addr);
        check("sw8_mem_wdata", mem_wdata);
        check("sw8_stall", {31'd0, stall});

        // Asynchronous reset in the middle of WRITE
        @(negedge clk);
        drive(1, 1, F3_B, 32'h9, 32'h00000055);
        push(1);
        #1 check("sb9_c1_stall", {31'd0, stall});
        @(negedge clk);
        drive(0, 0, F3_B, 32'h0, 32'h0);
        push(1); push(32'hdead55ef);
        #1;
        check("sb9_write", {31'd0, mem_write});
        check("sb9_wdata", mem_wdata);
        wr0 = wr_count;
        #2 rst = 1'b1;
        push(0); push(0);
        #1;
        check("rst_mid_write", {31'd0, mem_write});
        check("rst_mid_stall", {31'd0, stall});
        @(negedge clk);
        rst = 1'b0;
        push(0); push(0); push(0);
        #1;
        check("post_rst_sticky", {31'd0, fault_sticky});
        check("post_rst_fault_addr", fault_addr);
        check("post_rst_idle_write", {31'd0, mem_write});
        @(negedge clk);
        drive(1, 0, F3_W, 32'h8, 32'h0);
        push(32'hdeadbeef); push(0);
        #1;
        check("post_rst_mem", rdata);
        check("post_rst_wr_count", wr_count - wr0);

        @(negedge clk);
        drive(0, 0, F3_B, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
